// File: rtl/hazard_ctrl.sv
// Hazard controller beside the decode stage: load-use stalls, branch flushes,
// memory freeze and registered EX forwarding selects from a 3-entry scoreboard.
module hazard_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [4:0]  ZERO_REG = 5'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic [4:0]       id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             branch_taken,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_LOAD_USE,
    MODE_FLUSH,
    MODE_FREEZE
  } mode_e;

  typedef struct packed {
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } sb_entry_t;

  sb_entry_t  sb_ex, sb_mem, sb_wb, ex_next;
  mode_e      mode;
  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       rs_used, rt_used, rs_live, rt_live;
  logic       load_use, bubble_in;
  logic [1:0] fwd_a_next, fwd_b_next;
  logic       unused_bits;

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];

  // WB entry and MEM load flag are tracked for completeness but feed no select.
  assign unused_bits = ^{id_instr[15:0], sb_wb, sb_mem.mem_read};

  always_comb begin
    rs_used = !((opcode == 6'b000010) || (opcode == 6'b000011));
    rt_used = (opcode == 6'b000000) || (opcode == 6'b000100) ||
              (opcode == 6'b000101) || (opcode == 6'b101011);
  end

  assign rs_live  = rs_used && (rs != ZERO_REG);
  assign rt_live  = rt_used && (rt != ZERO_REG);
  assign load_use = id_valid && sb_ex.mem_read && sb_ex.reg_write &&
                    ((rs_live && (rs == sb_ex.dest)) || (rt_live && (rt == sb_ex.dest)));

  always_comb begin
    mode = MODE_RUN;
    if (!rst)              mode = MODE_RUN;
    else if (mem_stall)    mode = MODE_FREEZE;
    else if (branch_taken) mode = MODE_FLUSH;
    else if (load_use)     mode = MODE_LOAD_USE;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    case (mode)
      MODE_FREEZE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
      MODE_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end
      MODE_LOAD_USE: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Newer producer (EX, becoming EX/MEM) wins; a load in EX can only be taken from MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input sb_entry_t ex_e,
                                          input sb_entry_t mem_e);
    if (src == ZERO_REG)
      return 2'b00;
    if (ex_e.reg_write && !ex_e.mem_read && (ex_e.dest == src))
      return 2'b10;
    if (mem_e.reg_write && (mem_e.dest == src))
      return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    bubble_in  = idex_bubble || !id_valid;
    ex_next    = bubble_in ? '0 : {id_dest, id_reg_write, id_mem_read};
    fwd_a_next = bubble_in ? 2'b00 : fwd_sel(rs, sb_ex, sb_mem);
    fwd_b_next = bubble_in ? 2'b00 : fwd_sel(rt, sb_ex, sb_mem);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (mode)
        MODE_FREEZE: ;
        MODE_FLUSH: begin
          sb_ex  <= '0;
          sb_mem <= '0;
          sb_wb  <= sb_mem;
          fwd_a  <= 2'b00;
          fwd_b  <= 2'b00;
          if (flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
        end
        default: begin
          sb_ex  <= ex_next;
          sb_mem <= sb_ex;
          sb_wb  <= sb_mem;
          fwd_a  <= fwd_a_next;
          fwd_b  <= fwd_b_next;
          if ((mode == MODE_LOAD_USE) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random
// instruction streams compared against an in-flight pipeline model.
module tb_hazard_ctrl;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [31:0]   id_instr;
  logic          id_valid;
  logic [4:0]    id_dest;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          branch_taken;
  logic          mem_stall;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CNT_W(CW), .ZERO_REG(5'd0)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .mem_stall(mem_stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-flight producers: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } ent_t;

  ent_t       pipe[3];
  logic [1:0] m_fwd_a, m_fwd_b;
  int         m_stall, m_flush;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{5'd0, 1'b0, 1'b0};
    m_fwd_a = 2'b00;
    m_fwd_b = 2'b00;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (pipe[0].rw && !pipe[0].mr && pipe[0].dest == src) return 2'b10;
    if (pipe[1].rw && pipe[1].dest == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic valid, input logic [4:0] dest,
                       input logic rw, input logic mr, input logic br, input logic ms);
    id_instr     = instr;
    id_valid     = valid;
    id_dest      = dest;
    id_reg_write = rw;
    id_mem_read  = mr;
    branch_taken = br;
    mem_stall    = ms;
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model past the rising edge.
  task automatic apply_stimulus(input logic [31:0] instr, input logic valid, input logic [4:0] dest,
                                input logic rw, input logic mr, input logic br, input logic ms);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, hit, bub;
    ent_t       entering;
    logic [1:0] na, nb;
    drive(instr, valid, dest, rw, mr, br, ms);
    op     = instr[31:26];
    rs     = instr[25:21];
    rt     = instr[20:16];
    use_rs = !(op == 6'd2 || op == 6'd3);
    use_rt = (op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'd43);
    hit    = valid && pipe[0].mr && pipe[0].rw &&
             ((use_rs && rs != 5'd0 && rs == pipe[0].dest) ||
              (use_rt && rt != 5'd0 && rt == pipe[0].dest));
    @(negedge clk);
    check_output("pc_write",    32'(pc_write),    32'(!(ms || (!br && hit))));
    check_output("ifid_write",  32'(ifid_write),  32'(!(ms || (!br && hit))));
    check_output("ifid_flush",  32'(ifid_flush),  32'(!ms && br));
    check_output("idex_bubble", 32'(idex_bubble), 32'(!ms && (br || hit)));
    check_output("exmem_flush", 32'(exmem_flush), 32'(!ms && br));
    check_output("fwd_a",       32'(fwd_a),       32'(m_fwd_a));
    check_output("fwd_b",       32'(fwd_b),       32'(m_fwd_b));
    check_output("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    check_output("flush_cnt",   32'(flush_cnt),   32'(m_flush));
    if (!ms) begin
      if (br) begin
        pipe[2] = pipe[1];
        pipe[1] = '{5'd0, 1'b0, 1'b0};
        pipe[0] = '{5'd0, 1'b0, 1'b0};
        m_fwd_a = 2'b00;
        m_fwd_b = 2'b00;
        if (m_flush < MAXC) m_flush++;
      end else begin
        bub      = hit || !valid;
        entering = bub ? '{5'd0, 1'b0, 1'b0} : '{dest, rw, mr};
        na       = bub ? 2'b00 : model_fwd(rs);
        nb       = bub ? 2'b00 : model_fwd(rt);
        pipe[2]  = pipe[1];
        pipe[1]  = pipe[0];
        pipe[0]  = entering;
        m_fwd_a  = na;
        m_fwd_b  = nb;
        if (hit && m_stall < MAXC) m_stall++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop_cycle();
    apply_stimulus(32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw_r2(input logic ms);
    apply_stimulus(mk(6'd35, 5'd1, 5'd2, 5'd0), 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, ms);
  endtask

  task automatic add_r3_r2(input logic br, input logic ms);
    apply_stimulus(mk(6'd0, 5'd2, 5'd4, 5'd3), 1'b1, 5'd3, 1'b1, 1'b0, br, ms);
  endtask

  task automatic random_cycle();
    int         k;
    logic [5:0] op;
    logic [4:0] rs, rt, rd, dest;
    logic       rw, mr, valid, br, ms;
    k     = $urandom_range(0, 5);
    rs    = 5'($urandom_range(0, 3));
    rt    = 5'($urandom_range(0, 3));
    rd    = 5'($urandom_range(0, 3));
    valid = ($urandom_range(0, 7) != 0);
    br    = ($urandom_range(0, 15) == 0);
    ms    = ($urandom_range(0, 9) == 0);
    rw    = 1'b0;
    mr    = 1'b0;
    dest  = rd;
    case (k)
      0: begin op = 6'd0;  rw = 1'b1; end
      1: begin op = 6'd35; rw = 1'b1; mr = 1'b1; dest = rt; end
      2: op = 6'd43;
      3: op = 6'd4;
      4: op = 6'd2;
      default: begin op = 6'd8; rw = 1'b1; dest = rt; end
    endcase
    apply_stimulus(mk(op, rs, rt, rd), valid, dest, rw, mr, br, ms);
  endtask

  initial begin
    rst = 1'b0;
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    nop_cycle();

    // Load-use: one stall, then the add sees the load in MEM.
    lw_r2(1'b0);
    add_r3_r2(1'b0, 1'b0);
    add_r3_r2(1'b0, 1'b0);
    check_output("plan_lu_fwd_a", 32'(fwd_a), 32'd1);
    check_output("plan_lu_cnt", 32'(stall_cnt), 32'd1);
    nop_cycle();

    // Back-to-back ALU dependency, then with one bubble between.
    apply_stimulus(mk(6'd0, 5'd1, 5'd1, 5'd5), 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(mk(6'd0, 5'd5, 5'd5, 5'd6), 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("plan_exmem_a", 32'(fwd_a), 32'd2);
    check_output("plan_exmem_b", 32'(fwd_b), 32'd2);
    apply_stimulus(mk(6'd0, 5'd1, 5'd1, 5'd5), 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    nop_cycle();
    apply_stimulus(mk(6'd0, 5'd5, 5'd5, 5'd6), 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("plan_memwb_a", 32'(fwd_a), 32'd1);
    check_output("plan_memwb_b", 32'(fwd_b), 32'd1);

    // Zero register never creates a hazard.
    apply_stimulus(mk(6'd35, 5'd1, 5'd0, 5'd0), 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(mk(6'd0, 5'd0, 5'd0, 5'd1), 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("plan_zero_cnt", 32'(stall_cnt), 32'd1);
    check_output("plan_zero_fwd", 32'(fwd_a), 32'd0);

    // Branch flush beats a pending load-use.
    lw_r2(1'b0);
    add_r3_r2(1'b1, 1'b0);
    check_output("plan_flush_cnt", 32'(flush_cnt), 32'd1);
    check_output("plan_flush_stall", 32'(stall_cnt), 32'd1);

    // Freeze during a load-use, then a single stall.
    lw_r2(1'b0);
    repeat (3) add_r3_r2(1'b0, 1'b1);
    add_r3_r2(1'b0, 1'b0);
    add_r3_r2(1'b0, 1'b0);
    check_output("plan_freeze_cnt", 32'(stall_cnt), 32'd2);

    // Drive the stall counter into saturation.
    for (int i = 0; i < MAXC + 4; i++) begin
      lw_r2(1'b0);
      add_r3_r2(1'b0, 1'b0);
      add_r3_r2(1'b0, 1'b0);
    end
    check_output("plan_sat_cnt", 32'(stall_cnt), 32'(MAXC));

    // Asynchronous reset in the middle of a stall.
    lw_r2(1'b0);
    drive(mk(6'd0, 5'd2, 5'd4, 5'd3), 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("rst_pre_stall", 32'(pc_write), 32'd0);
    rst = 1'b0;
    #1;
    check_output("rst_pc_write", 32'(pc_write), 32'd1);
    check_output("rst_ifid_write", 32'(ifid_write), 32'd1);
    check_output("rst_bubble", 32'(idex_bubble), 32'd0);
    check_output("rst_ifid_flush", 32'(ifid_flush), 32'd0);
    check_output("rst_exmem_flush", 32'(exmem_flush), 32'd0);
    check_output("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    check_output("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_output("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    add_r3_r2(1'b0, 1'b0);

    for (int i = 0; i < 500; i++) random_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
